// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory-port arbiter (IF vs LSU).
package mem_arb_pkg;

  // Master identifiers, also used as the grant / owner encoding
  localparam logic MST_IF = 1'b0;
  localparam logic MST_LS = 1'b1;

  // Arbiter FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Instruction returned to fetch when memory never answers (addi x0,x0,0)
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // Instruction fetch channel
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_resp_err;

  // Load/store channel
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_wen;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_wmask;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_resp_err;

  // Memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata, if_resp_err,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output ls_req_ready, ls_resp_valid, ls_rdata, ls_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  // Requester / memory view
  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata, if_resp_err,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  ls_req_ready, ls_resp_valid, ls_rdata, ls_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Two-way grant selection between IF and LSU.
// MEM_ARB_RR_EN defined: round-robin with grant frozen across a stalled request.
// MEM_ARB_RR_EN undefined: fixed priority, LSU over IF.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic hs,
  input  logic stall,
  output logic grant_c,
  output logic any_valid_c
);

  assign any_valid_c = if_valid | ls_valid;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr;
  logic hold_q;
  logic hold_gnt;
  logic arb_c;

  // Round-robin pick; a lone requester wins regardless of the pointer
  always_comb begin
    arb_c = MST_IF;
    if (if_valid & ls_valid) arb_c = rr_ptr;
    else if (ls_valid)       arb_c = MST_LS;
  end

  // A request presented but not accepted keeps its grant
  assign grant_c = hold_q ? hold_gnt : arb_c;

  // Pointer advances past the winner on every handshake; hold tracks stalls
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr   <= MST_IF;
      hold_q   <= 1'b0;
      hold_gnt <= MST_IF;
    end else begin
      hold_q   <= stall;
      hold_gnt <= grant_c;
      if (hs) rr_ptr <= ~grant_c;
    end
  end
`else
  logic unused_rr_c;

  assign grant_c     = ls_valid ? MST_LS : MST_IF;
  assign unused_rr_c = ^{clock, reset, hs, stall};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU: one
// outstanding transaction, response steered to its owner, watchdog timeout.
// Optional feature macro: MEM_ARB_RR_EN (round-robin grant).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC);

  state_e            state;
  logic              owner;
  logic              owner_wen;
  logic [WDOG_W-1:0] wdog;

  logic              grant_c;
  logic              any_valid_c;
  logic              resp_busy_c;
  logic              req_valid_c;
  logic              hs_c;
  logic              stall_c;
  logic              timeout_c;
  logic [ADDR_W-1:0] addr_c;
  logic              wen_c;
  logic [DATA_W-1:0] wdata_c;
  logic [3:0]        wmask_c;

  mem_arb_grant u_grant (
    .clock       (clock),
    .reset       (reset),
    .if_valid    (bus.if_req_valid),
    .ls_valid    (bus.ls_req_valid),
    .hs          (hs_c),
    .stall       (stall_c),
    .grant_c     (grant_c),
    .any_valid_c (any_valid_c)
  );

  // No new request in the cycle that carries a response strobe
  assign resp_busy_c = bus.if_resp_valid | bus.ls_resp_valid;
  assign req_valid_c = (state == ST_IDLE) & any_valid_c & ~resp_busy_c;
  assign hs_c        = req_valid_c & bus.mem_req_ready;
  assign stall_c     = req_valid_c & ~bus.mem_req_ready;
  assign timeout_c   = (wdog == WDOG_W'(TIMEOUT_CYC - 1));

  // Request fields from the granted master; fetch never writes
  always_comb begin
    addr_c  = bus.if_addr;
    wen_c   = 1'b0;
    wdata_c = '0;
    wmask_c = '0;
    if (grant_c == MST_LS) begin
      addr_c  = bus.ls_addr;
      wen_c   = bus.ls_wen;
      wdata_c = bus.ls_wdata;
      wmask_c = bus.ls_wmask;
    end
  end

  assign bus.mem_req_valid = req_valid_c;
  assign bus.mem_addr      = addr_c;
  assign bus.mem_wen       = wen_c;
  assign bus.mem_wdata     = wdata_c;
  assign bus.mem_wmask     = wmask_c;
  assign bus.if_req_ready  = hs_c & (grant_c == MST_IF);
  assign bus.ls_req_ready  = hs_c & (grant_c == MST_LS);

  // Transaction FSM, watchdog and registered response demux
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= ST_IDLE;
      owner             <= MST_IF;
      owner_wen         <= 1'b0;
      wdog              <= '0;
      bus.if_resp_valid <= 1'b0;
      bus.if_rdata      <= '0;
      bus.if_resp_err   <= 1'b0;
      bus.ls_resp_valid <= 1'b0;
      bus.ls_rdata      <= '0;
      bus.ls_resp_err   <= 1'b0;
    end else begin
      bus.if_resp_valid <= 1'b0;
      bus.ls_resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs_c) begin
            owner     <= grant_c;
            owner_wen <= (grant_c == MST_LS) & bus.ls_wen;
            wdog      <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wdog <= wdog + WDOG_W'(1);
          if (bus.mem_resp_valid) begin
            state <= ST_IDLE;
            if (owner == MST_IF) begin
              bus.if_resp_valid <= 1'b1;
              bus.if_rdata      <= bus.mem_rdata;
              bus.if_resp_err   <= 1'b0;
            end else begin
              bus.ls_resp_valid <= 1'b1;
              bus.ls_rdata      <= owner_wen ? '0 : bus.mem_rdata;
              bus.ls_resp_err   <= 1'b0;
            end
          end else if (timeout_c) begin
            state <= ST_IDLE;
            if (owner == MST_IF) begin
              bus.if_resp_valid <= 1'b1;
              bus.if_rdata      <= DATA_W'(NOP_INSN);
              bus.if_resp_err   <= 1'b1;
            end else begin
              bus.ls_resp_valid <= 1'b1;
              bus.ls_rdata      <= '0;
              bus.ls_resp_err   <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int          TMO         = int'(TIMEOUT_CYC);

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model of the outstanding transaction (cycle numbers)
  int          wait_lo  = -1;
  int          wait_hi  = -1;
  int          strb_cyc = -1;
  int          resp_at  = -1;
  logic        own_m    = MST_IF;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] resp_word;
  logic        rr_m     = MST_IF;
  logic        frz_m    = 1'b0;
  logic        frz_g    = MST_IF;

  // Requesters
  logic        if_pend = 1'b0;
  logic        ls_pend = 1'b0;
  logic [31:0] if_a = '0, ls_a = '0, ls_d = '0;
  logic        ls_w = 1'b0;
  logic [3:0]  ls_m = '0;

  // Scenario knobs
  bit          rand_on    = 1'b0;
  int          rdy_mode   = 1;   // -1 random, else fixed level
  int          lat_mode   = 1;   // -2 random, 0 never respond, else WAIT cycles
  bit          force_resp = 1'b0;
  bit          data_set   = 1'b0;
  logic [31:0] data_val   = '0;

  int          hs_cyc[$];
  logic [31:0] hs_addr[$];
  int          if_strobes = 0;
  int          ls_strobes = 0;
  int          last_if_strobe = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic set_if(input logic [31:0] a);
    if_pend = 1'b1;
    if_a    = a;
  endtask

  task automatic set_ls(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    ls_pend = 1'b1;
    ls_a    = a;
    ls_w    = w;
    ls_d    = d;
    ls_m    = m;
  endtask

  task automatic model_clear();
    wait_lo  = -1;
    wait_hi  = -1;
    strb_cyc = -1;
    resp_at  = -1;
    rr_m     = MST_IF;
    frz_m    = 1'b0;
    if_pend  = 1'b0;
    ls_pend  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    cyc++;
    reset = 1'b0;
    model_clear();
    bus.if_req_valid   = 1'b0;
    bus.ls_req_valid   = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    repeat (n) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("rst_if_resp_valid", bus.if_resp_valid, 1'b0);
    check_eq("rst_if_rdata", bus.if_rdata, 32'h0);
    check_eq("rst_if_err", bus.if_resp_err, 1'b0);
    check_eq("rst_ls_resp_valid", bus.ls_resp_valid, 1'b0);
    check_eq("rst_ls_rdata", bus.ls_rdata, 32'h0);
    check_eq("rst_ls_err", bus.ls_resp_err, 1'b0);
    check_eq("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    reset = 1'b1;
  endtask

  // One clock: check registered outputs, drive inputs, check the request path
  task automatic step();
    logic g, mv, hs;
    bit   in_wait;
    int   lat, r;
    @(negedge clock);
    cyc++;
    if (bus.if_resp_valid === 1'b1) begin
      if_strobes++;
      last_if_strobe = cyc;
    end
    if (bus.ls_resp_valid === 1'b1) ls_strobes++;
    check_eq("if_resp_valid", bus.if_resp_valid, (cyc == strb_cyc) && (own_m == MST_IF));
    check_eq("ls_resp_valid", bus.ls_resp_valid, (cyc == strb_cyc) && (own_m == MST_LS));
    if (cyc == strb_cyc) begin
      if (own_m == MST_IF) begin
        check_eq("if_rdata", bus.if_rdata, exp_rdata);
        check_eq("if_resp_err", bus.if_resp_err, exp_err);
      end else begin
        check_eq("ls_rdata", bus.ls_rdata, exp_rdata);
        check_eq("ls_resp_err", bus.ls_resp_err, exp_err);
      end
    end

    if (rand_on) begin
      if (!if_pend && $urandom_range(0, 2) == 0) set_if($urandom);
      if (!ls_pend && $urandom_range(0, 2) == 0)
        set_ls($urandom, 1'($urandom), $urandom, 4'($urandom));
    end
    bus.if_req_valid  = if_pend;
    bus.if_addr       = if_a;
    bus.ls_req_valid  = ls_pend;
    bus.ls_addr       = ls_a;
    bus.ls_wen        = ls_w;
    bus.ls_wdata      = ls_d;
    bus.ls_wmask      = ls_m;
    bus.mem_req_ready = (rdy_mode < 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode != 0);
    in_wait = (cyc >= wait_lo) && (cyc <= wait_hi);
    bus.mem_resp_valid = (cyc == resp_at) || force_resp ||
                         (rand_on && !in_wait && $urandom_range(0, 9) == 0);
    bus.mem_rdata = (cyc == resp_at) ? resp_word : $urandom;
    #1;

    mv = !in_wait && (cyc != strb_cyc) && (if_pend || ls_pend);
`ifdef MEM_ARB_RR_EN
    if (frz_m)                  g = frz_g;
    else if (if_pend && ls_pend) g = rr_m;
    else                        g = ls_pend ? MST_LS : MST_IF;
`else
    g = ls_pend ? MST_LS : MST_IF;
`endif
    hs = mv && bus.mem_req_ready;
    check_eq("mem_req_valid", bus.mem_req_valid, mv);
    check_eq("if_req_ready", bus.if_req_ready, hs && (g == MST_IF));
    check_eq("ls_req_ready", bus.ls_req_ready, hs && (g == MST_LS));
    if (mv) begin
      check_eq("mem_addr", bus.mem_addr, (g == MST_LS) ? ls_a : if_a);
      check_eq("mem_wen", bus.mem_wen, (g == MST_LS) && ls_w);
      check_eq("mem_wdata", bus.mem_wdata, (g == MST_LS) ? ls_d : 32'h0);
      check_eq("mem_wmask", bus.mem_wmask, (g == MST_LS) ? ls_m : 4'h0);
    end
    frz_m = mv && !bus.mem_req_ready;
    frz_g = g;

    if (hs) begin
      hs_cyc.push_back(cyc);
      hs_addr.push_back(bus.mem_addr);
      if (lat_mode == -2) begin
        r   = int'($urandom_range(0, 15));
        lat = (r == 0) ? 0 : (r == 1) ? TMO : 1 + (r % 4);
      end else begin
        lat = lat_mode;
      end
      own_m     = g;
      resp_word = data_set ? data_val : $urandom;
      wait_lo   = cyc + 1;
      if (lat >= 1 && lat <= TMO) begin
        resp_at   = cyc + lat;
        wait_hi   = cyc + lat;
        exp_err   = 1'b0;
        exp_rdata = ((g == MST_LS) && ls_w) ? 32'h0 : resp_word;
      end else begin
        resp_at   = -1;
        wait_hi   = cyc + TMO;
        exp_err   = 1'b1;
        exp_rdata = (g == MST_IF) ? NOP_INSN : 32'h0;
      end
      strb_cyc = wait_hi + 1;
      rr_m     = ~g;
      if (g == MST_LS) ls_pend = 1'b0;
      else             if_pend = 1'b0;
    end
  endtask

  // Run until both requesters are served and the last response is out
  task automatic drain();
    int n = 0;
    while ((if_pend || ls_pend || cyc < strb_cyc) && n < 400) begin
      step();
      n++;
    end
    check_eq("drain_in_budget", n < 400, 1'b1);
  endtask

  initial begin
    int s0;
    bus.if_req_valid   = 1'b0;
    bus.if_addr        = '0;
    bus.ls_req_valid   = 1'b0;
    bus.ls_addr        = '0;
    bus.ls_wen         = 1'b0;
    bus.ls_wdata       = '0;
    bus.ls_wmask       = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;

    // Single fetch, memory answers one cycle after acceptance
    do_reset(2);
    rdy_mode = 1; lat_mode = 1; data_set = 1'b1; data_val = 32'h0010_0093;
    set_if(32'h8000_0000);
    drain();
    check_eq("t1_if_strobes", if_strobes, 1);
    check_eq("t1_ls_strobes", ls_strobes, 0);

    // Simultaneous requests: order and back-to-back spacing
    do_reset(2);
    data_set = 1'b0; lat_mode = 2;
    hs_cyc.delete(); hs_addr.delete();
    set_if(32'h8000_0004);
    set_ls(32'h8000_1000, 1'b0, 32'h0, 4'hF);
    drain();
    check_eq("t2_hs_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) begin
`ifdef MEM_ARB_RR_EN
      check_eq("t2_first_grant", hs_addr[0], 32'h8000_0004);
`else
      check_eq("t2_first_grant", hs_addr[0], 32'h8000_1000);
`endif
      check_eq("t2_regrant_gap", hs_cyc[1] - hs_cyc[0], 4);
    end

    // LSU write
    lat_mode = 1;
    set_ls(32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    drain();

    // Fetch that memory never answers, then a late response, then normal fetch
    lat_mode = 0;
    hs_cyc.delete(); hs_addr.delete();
    set_if(32'h8000_0008);
    drain();
    if (hs_cyc.size() > 0)
      check_eq("t4_timeout_latency", last_if_strobe - hs_cyc[0], TMO + 1);
    s0 = if_strobes;
    force_resp = 1'b1;
    step();
    force_resp = 1'b0;
    repeat (2) step();
    check_eq("t4_late_resp_dropped", if_strobes - s0, 0);
    lat_mode = 3;
    set_if(32'h8000_000C);
    drain();

    // Reset in the middle of a transaction, then a stale memory response
    lat_mode = 0;
    set_if(32'h8000_0010);
    repeat (6) step();
    s0 = if_strobes;
    do_reset(1);
    force_resp = 1'b1;
    step();
    force_resp = 1'b0;
    repeat (3) step();
    check_eq("t5_no_strobe_after_reset", if_strobes - s0, 0);
    lat_mode = 2;
    set_if(32'h8000_0014);
    drain();
    check_eq("t5_served_after_reset", if_strobes - s0, 1);

    // Memory stalls with both masters requesting
    rdy_mode = 0;
    set_if(32'h8000_0020);
    set_ls(32'h8000_1020, 1'b0, 32'h0, 4'h3);
    repeat (3) step();
    rdy_mode = 1;
    drain();

    // Random traffic
    rand_on = 1'b1; rdy_mode = -1; lat_mode = -2;
    repeat (3000) step();
    rand_on = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
